fft_reorder: RTL and testbench

FFT_REORDER -- requirements
Module: fft_reorder

---
 rtl/fft_reorder_pkg.sv | 37 +++
 rtl/fft_reorder_ram.sv | 40 ++++
 rtl/fft_reorder.sv | 208 ++++++++++++++++++++
 tb/tb_fft_reorder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_reorder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_reorder_pkg
// Purpose  : Shared FFT output parameter set (frame size, index width, sample
//            width), write/read state encodings and the bit-reversal helper
//            used to map fft_r22sdf output order onto natural bin order.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fft_reorder_pkg;

  localparam int FFT_N_DEF     = 1024;
  localparam int FFT_NLOG2_DEF = 10;
  localparam int OW_DEF        = 25;

  typedef enum logic [1:0] {
    W_ALIGN = 2'd0,
    W_FILL  = 2'd1,
    W_DROP  = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_t;

  // Mirror the index bits: bit i of the result is bit (NLOG2-1-i) of x.
  function automatic logic [FFT_NLOG2_DEF-1:0] bitrev(input logic [FFT_NLOG2_DEF-1:0] x);
    logic [FFT_NLOG2_DEF-1:0] r;
    for (int i = 0; i < FFT_NLOG2_DEF; i++) begin
      r[i] = x[FFT_NLOG2_DEF-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_reorder_ram
// Purpose  : Simple dual-port RAM with registered read, block-RAM inferable.
//            The top uses the address MSB as the ping-pong bank select.
// Ports    : clk      - clock
//            wr_en    - write strobe
//            wr_addr  - write address
//            wr_data  - write data
//            rd_en    - read enable; rd_data holds while low
//            rd_addr  - read address
//            rd_data  - registered read data (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module fft_reorder_ram #(
  parameter int AW = 11,
  parameter int DW = 50
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_reorder
// Purpose  : Converts the bit-reversed FFT output stream into natural bin
//            order using a ping-pong pair of frame banks, and streams the
//            frames out with a valid/ready handshake.
// Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//            ce_i, sync_i          - input qualifiers (write when both high)
//            data_ctr_i            - bit-reversed FFT output index
//            data_re_i, data_im_i  - signed input sample
//            ready_i               - downstream accepts current beat
//            valid_o, last_o       - beat valid / beat is bin FFT_N-1
//            bin_o                 - natural-order bin index
//            data_re_o, data_im_o  - signed reordered sample
//            overflow_o            - one-cycle pulse per dropped input frame
// Revision : 1.0 - initial release
// ============================================================================
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int FFT_N     = FFT_N_DEF,
  parameter int FFT_NLOG2 = FFT_NLOG2_DEF,
  parameter int OW        = OW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ce_i,
  input  logic                 sync_i,
  input  logic [FFT_NLOG2-1:0] data_ctr_i,
  input  logic signed [OW-1:0] data_re_i,
  input  logic signed [OW-1:0] data_im_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic                 last_o,
  output logic [FFT_NLOG2-1:0] bin_o,
  output logic signed [OW-1:0] data_re_o,
  output logic signed [OW-1:0] data_im_o,
  output logic                 overflow_o
);

  localparam logic [FFT_NLOG2-1:0] LAST_IDX = FFT_NLOG2'(FFT_N - 1);

  // ---------------- write side ----------------
  wr_state_t            wr_state, wr_state_nxt;
  logic                 wr_bank;
  logic [1:0]           full, full_nxt;
  logic [FFT_NLOG2-1:0] prev_idx;
  logic                 in_valid, wr_en, set_full, drop_pulse;
  logic [FFT_NLOG2:0]   wr_addr;

  // ---------------- read side -----------------
  rd_state_t            rd_state, rd_state_nxt;
  logic                 rd_bank;
  logic [FFT_NLOG2-1:0] rd_cnt;
  logic                 advance, issue, accept_last;
  logic [FFT_NLOG2:0]   rd_addr;
  logic [2*OW-1:0]      ram_rd;
  logic                 p1_valid, p1_bank, out_bank;
  logic [FFT_NLOG2-1:0] p1_bin;

  assign in_valid = ce_i && sync_i;
  assign wr_addr  = {wr_bank, bitrev(data_ctr_i)};

  always_comb begin
    wr_state_nxt = wr_state;
    wr_en        = 1'b0;
    set_full     = 1'b0;
    drop_pulse   = 1'b0;
    case (wr_state)
      W_ALIGN: begin
        if (in_valid && data_ctr_i == '0) begin
          if (!full[wr_bank]) begin
            wr_en        = 1'b1;
            wr_state_nxt = W_FILL;
          end else begin
            drop_pulse   = 1'b1;
            wr_state_nxt = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          if (data_ctr_i == prev_idx + FFT_NLOG2'(1)) begin
            wr_en = 1'b1;
            if (data_ctr_i == LAST_IDX) begin
              set_full     = 1'b1;
              wr_state_nxt = W_ALIGN;
            end
          end else begin
            // Index gap: the partial bank is abandoned and stays not-full.
            drop_pulse   = 1'b1;
            wr_state_nxt = W_ALIGN;
          end
        end
      end
      W_DROP: begin
        if (in_valid && data_ctr_i == LAST_IDX) begin
          wr_state_nxt = W_ALIGN;
        end
      end
      default: wr_state_nxt = W_ALIGN;
    endcase
  end

  // Both pipeline stages share one enable, so a stall freezes RAM output and
  // output register together and no skid buffer is needed.
  assign advance     = !valid_o || ready_i;
  assign accept_last = valid_o && ready_i && last_o;
  assign rd_addr     = {rd_bank, rd_cnt};

  // rd_bank moves to the other bank as soon as its last address is issued,
  // so a waiting full bank starts with no bubble; the bank itself is only
  // released when its last beat is accepted (tracked through out_bank).
  always_comb begin
    rd_state_nxt = rd_state;
    issue        = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (advance && full[rd_bank]) begin
          issue        = 1'b1;
          rd_state_nxt = R_READ;
        end
      end
      R_READ: begin
        if (advance) begin
          issue = 1'b1;
          if (rd_cnt == LAST_IDX) begin
            rd_state_nxt = R_IDLE;
          end
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Release and completion always target different banks, so both may
  // apply in the same cycle.
  always_comb begin
    full_nxt = full;
    if (accept_last) full_nxt[out_bank] = 1'b0;
    if (set_full)    full_nxt[wr_bank]  = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state   <= W_ALIGN;
      wr_bank    <= 1'b0;
      full       <= 2'b00;
      prev_idx   <= '0;
      overflow_o <= 1'b0;
      rd_state   <= R_IDLE;
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
    end else begin
      wr_state   <= wr_state_nxt;
      full       <= full_nxt;
      overflow_o <= drop_pulse;
      rd_state   <= rd_state_nxt;
      if (wr_en)    prev_idx <= data_ctr_i;
      if (set_full) wr_bank  <= ~wr_bank;
      if (issue) begin
        rd_cnt <= rd_cnt + FFT_NLOG2'(1);
        if (rd_cnt == LAST_IDX) rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_valid  <= 1'b0;
      p1_bin    <= '0;
      p1_bank   <= 1'b0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      bin_o     <= '0;
      out_bank  <= 1'b0;
      data_re_o <= '0;
      data_im_o <= '0;
    end else if (advance) begin
      p1_valid <= issue;
      p1_bin   <= rd_cnt;
      p1_bank  <= rd_bank;
      valid_o  <= p1_valid;
      last_o   <= p1_valid && (p1_bin == LAST_IDX);
      out_bank <= p1_bank;
      if (p1_valid) begin
        bin_o     <= p1_bin;
        data_re_o <= ram_rd[2*OW-1:OW];
        data_im_o <= ram_rd[OW-1:0];
      end
    end
  end

  fft_reorder_ram #(
    .AW (FFT_NLOG2 + 1),
    .DW (2 * OW)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({data_re_i, data_im_i}),
    .rd_en   (advance),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_reorder
// Purpose  : Directed self-checking bench for fft_reorder: reset values,
//            impulse, index ramp, backpressure, overflow, reset mid-read,
//            misaligned start and aborted frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_reorder;

  logic              clk = 1'b0;
  logic              rst_i, ce_i, sync_i, ready_i = 1'b1;
  logic [9:0]        data_ctr_i;
  logic signed [24:0] data_re_i, data_im_i;
  logic              valid_o, last_o, overflow_o;
  logic [9:0]        bin_o;
  logic signed [24:0] data_re_o, data_im_o;

  always #5 clk = ~clk;

  fft_reorder dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .ce_i       (ce_i),
    .sync_i     (sync_i),
    .data_ctr_i (data_ctr_i),
    .data_re_i  (data_re_i),
    .data_im_i  (data_im_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .bin_o      (bin_o),
    .data_re_o  (data_re_o),
    .data_im_o  (data_im_o),
    .overflow_o (overflow_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: ~30% random
  bit gap_en = 0;

  int exp_pat[$];
  int exp_tag[$];
  int beat_idx = 0;
  int frames_done = 0;
  int ovf_cnt = 0;
  int start_cyc[16];
  int end_cyc[16];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < 10; i++) if (k & (1 << i)) r |= 1 << (9 - i);
    return r;
  endfunction

  function automatic int samp_re(input int pat, input int tag, input int c);
    if (pat == 0) return (c == 0) ? 1000 : 0;
    return tag * 2048 + c;
  endfunction

  function automatic int samp_im(input int pat, input int c);
    if (pat == 0) return 0;
    return -c;
  endfunction

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: ready_i = 1'b1;
      1: ready_i = 1'b0;
      default: ready_i = ($urandom_range(0, 9) < 3);
    endcase
  end

  // Output monitor: scoreboard of expected frames plus hold-while-stalled.
  bit stall_q = 0;
  longint bin_q, re_q, im_q, last_q;
  always @(negedge clk) begin
    if (rst_i) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        check("stall_valid", valid_o, 1);
        check("stall_bin", bin_o, bin_q);
        check("stall_re", data_re_o, re_q);
        check("stall_im", data_im_o, im_q);
        check("stall_last", last_o, last_q);
      end
      if (valid_o && ready_i) begin
        if (exp_tag.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          int c;
          c = brev(beat_idx);
          check("bin", bin_o, beat_idx);
          check("re", data_re_o, samp_re(exp_pat[0], exp_tag[0], c));
          check("im", data_im_o, samp_im(exp_pat[0], c));
          check("last", last_o, (beat_idx == 1023) ? 1 : 0);
          if (beat_idx == 0) start_cyc[frames_done] = cyc;
          if (beat_idx == 1023) begin
            end_cyc[frames_done] = cyc;
            void'(exp_pat.pop_front());
            void'(exp_tag.pop_front());
            frames_done++;
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
      end
      if (overflow_o) ovf_cnt++;
      stall_q = valid_o && !ready_i;
      bin_q = bin_o; re_q = data_re_o; im_q = data_im_o; last_q = last_o;
    end
  end

  task automatic expect_frame(input int pat, input int tag);
    exp_pat.push_back(pat);
    exp_tag.push_back(tag);
  endtask

  task automatic send_seg(input int pat, input int tag, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        ce_i = $urandom_range(0, 1);
        sync_i = !ce_i;
        data_ctr_i = 10'($urandom);
        data_re_i = 25'($urandom);
        data_im_i = 25'($urandom);
      end
      @(posedge clk); #1;
      ce_i = 1'b1; sync_i = 1'b1;
      data_ctr_i = 10'(c);
      data_re_i = 25'(samp_re(pat, tag, c));
      data_im_i = 25'(samp_im(pat, c));
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    sync_i = 1'b0; ce_i = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  initial begin
    int n, ov0;
    bit found;
    rst_i = 1'b1; ce_i = 1'b0; sync_i = 1'b0;
    data_ctr_i = '0; data_re_i = '0; data_im_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_last", last_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_bin", bin_o, 0);
    check("rst_re", data_re_o, 0);
    check("rst_im", data_im_o, 0);
    @(posedge clk); #1 rst_i = 1'b0;

    // Impulse frame and first-beat latency
    expect_frame(0, 0);
    send_seg(0, 0, 0, 1023);
    idle();
    n = 0;
    do begin @(negedge clk); n++; end while (!valid_o && n < 20);
    check("first_valid_latency", n, 3);
    wait_frames(1, 3000);

    // Index ramp at full rate
    expect_frame(1, 0);
    send_seg(1, 0, 0, 1023);
    idle();
    wait_frames(2, 3000);
    check("ramp_span", end_cyc[1] - start_cyc[1], 1023);

    // Backpressure with qualifier gaps on the input
    rdy_mode = 2; gap_en = 1;
    expect_frame(1, 1);
    expect_frame(1, 2);
    send_seg(1, 1, 0, 1023);
    send_seg(1, 2, 0, 1023);
    gap_en = 0;
    idle();
    wait_frames(4, 20000);
    rdy_mode = 0;

    // Overflow: three frames while stalled, third dropped
    repeat (4) @(posedge clk);
    ov0 = ovf_cnt;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    expect_frame(1, 3);
    expect_frame(1, 4);
    send_seg(1, 3, 0, 1023);
    send_seg(1, 4, 0, 1023);
    send_seg(1, 5, 0, 1023);
    idle();
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("ovf_pulses", ovf_cnt - ov0, 1);
    check("ovf_hold_valid", valid_o, 1);
    check("ovf_hold_bin", bin_o, 0);
    rdy_mode = 0;
    wait_frames(6, 5000);
    check("ovf_span", end_cyc[5] - start_cyc[4], 2047);

    // Reset while reading bin 300
    expect_frame(1, 6);
    send_seg(1, 6, 0, 1023);
    idle();
    found = 0; n = 0;
    while (!found && n < 3000) begin
      @(negedge clk); #1; n++;
      if (valid_o && bin_o == 10'd300) found = 1;
    end
    check("reach_bin300", found, 1);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    exp_pat.delete(); exp_tag.delete(); beat_idx = 0;
    @(negedge clk);
    check("rst_mid_valid", valid_o, 0);
    expect_frame(1, 7);
    send_seg(1, 7, 0, 1023);
    idle();
    wait_frames(7, 3000);

    // Misaligned start: partial 700..1023 must be ignored
    ov0 = ovf_cnt;
    expect_frame(1, 9);
    send_seg(1, 8, 700, 1023);
    send_seg(1, 9, 0, 1023);
    idle();
    wait_frames(8, 3000);
    check("misalign_ovf", ovf_cnt - ov0, 0);

    // Index gap aborts the frame
    ov0 = ovf_cnt;
    expect_frame(1, 11);
    send_seg(1, 10, 0, 499);
    send_seg(1, 10, 501, 1023);
    send_seg(1, 11, 0, 1023);
    idle();
    wait_frames(9, 3000);
    check("abort_ovf", ovf_cnt - ov0, 1);
    check("leftover_frames", exp_tag.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
